// File: rtl/pc_gen_unit_pkg.sv
// Shared constants and types for the fetch-stage program-counter unit.
//   Default parameter values (address width, reset vector, instruction step, RAS depth)
//   npc_sel_e: which source the next-PC mux picks this cycle, highest priority first.
package pc_gen_unit_pkg;

  localparam int unsigned      DefaultXlen        = 32;
  localparam logic [31:0]      DefaultResetVector = 32'h0000_0000;
  localparam int unsigned      DefaultInstBytes   = 4;
  localparam int unsigned      DefaultRasDepth    = 4;

  typedef enum logic [2:0] {
    NpcFlush,
    NpcBranch,
    NpcHold,
    NpcRas,
    NpcSeq
  } npc_sel_e;

endpackage

// File: rtl/pc_gen_unit_ras_stack.sv
// Circular return address stack with a saturating occupancy count.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         write i_push_data above the current top
//   i_pop          drop the top entry (ignored when empty)
//   i_clear        discard all entries (count to 0)
//   i_push_data    return address to store
//   o_top_data     entry at the top pointer
//   o_empty/o_full occupancy flags, derived from the count register
module pc_gen_unit_ras_stack #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_push_data,
  output logic [XLEN-1:0] o_top_data,
  output logic            o_empty,
  output logic            o_full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] r_entries [DEPTH];
  logic [PtrW-1:0] r_top;
  logic [PtrW-1:0] w_top_d;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;
  logic            w_wr_en;
  logic [PtrW-1:0] w_wr_idx;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CntW'(DEPTH));
  assign o_top_data = r_entries[r_top];

  always_comb begin
    w_top_d   = r_top;
    w_count_d = r_count;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_top;
    if (i_clear) begin
      // Contents become stale; only the count matters for prediction.
      w_count_d = '0;
    end else if (i_push && i_pop && !o_empty) begin
      // Return then call in one cycle: the top slot is reused in place.
      w_wr_en = 1'b1;
    end else if (i_push) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_top + 1'b1;
      w_top_d   = r_top + 1'b1;
      // Pointer wraps over the oldest entry once full; count saturates.
      w_count_d = o_full ? r_count : r_count + 1'b1;
    end else if (i_pop && !o_empty) begin
      w_top_d   = r_top - 1'b1;
      w_count_d = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top   <= '0;
      r_count <= '0;
    end else begin
      r_top   <= w_top_d;
      r_count <= w_count_d;
    end
  end

  // Storage is not reset; the count keeps undefined entries from ever being used.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_entries[w_wr_idx] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter unit: holds the fetch PC and selects the next PC from
// trap flush, branch resolution, stall hold, RAS prediction or sequential increment.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 hold PC (backpressure); redirects still win
//   flush_valid, flush_pc trap redirect and target
//   br_taken              EX-resolved taken branch, target npc_op1 + npc_op2
//   ras_push, ras_pop     call / return detected at the current pc
//   pc                    registered fetch PC
//   npc                   value pc loads at the next edge
//   redirect              flush_valid | br_taken
//   ras_empty, ras_full   return address stack occupancy
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = DefaultXlen,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefaultResetVector),
  parameter int unsigned     INST_BYTES   = DefaultInstBytes,
  parameter int unsigned     RAS_DEPTH    = DefaultRasDepth
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] npc_op1,
  input  logic [XLEN-1:0] npc_op2,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            redirect,
  output logic            ras_empty,
  output logic            ras_full
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_br_sum;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_upd;
  npc_sel_e        w_sel;

  assign redirect = flush_valid | br_taken;
  assign w_seq_pc = r_pc + XLEN'(INST_BYTES);
  assign w_br_sum = npc_op1 + npc_op2;
  // The stack only tracks fetch that actually advances down the predicted path.
  assign w_ras_upd = !stall && !redirect;

  always_comb begin
    w_sel = NpcSeq;
    if (flush_valid) begin
      w_sel = NpcFlush;
    end else if (br_taken) begin
      w_sel = NpcBranch;
    end else if (stall) begin
      w_sel = NpcHold;
    end else if (ras_pop && !ras_empty) begin
      w_sel = NpcRas;
    end
  end

  always_comb begin
    npc = w_seq_pc;
    unique case (w_sel)
      NpcFlush:  npc = {flush_pc[XLEN-1:1], 1'b0};
      NpcBranch: npc = {w_br_sum[XLEN-1:1], 1'b0};
      NpcHold:   npc = r_pc;
      NpcRas:    npc = w_ras_top;
      default:   npc = w_seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= npc;
    end
  end

  assign pc = r_pc;

  pc_gen_unit_ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (ras_push && w_ras_upd),
    .i_pop       (ras_pop && w_ras_upd),
    .i_clear     (flush_valid),
    .i_push_data (w_seq_pc),
    .o_top_data  (w_ras_top),
    .o_empty     (ras_empty),
    .o_full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush_valid = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        br_taken = 1'b0;
  logic [31:0] npc_op1 = '0;
  logic [31:0] npc_op2 = '0;
  logic        ras_push = 1'b0;
  logic        ras_pop = 1'b0;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        redirect;
  logic        ras_empty;
  logic        ras_full;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        fl, br, st, pu, po;
    logic [31:0] fpc, op1, op2;
    logic [31:0] epc;
    logic        eempty, efull;
  } vec_t;

  vec_t sb[$];

  pc_gen_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush_valid (flush_valid),
    .flush_pc    (flush_pc),
    .br_taken    (br_taken),
    .npc_op1     (npc_op1),
    .npc_op2     (npc_op2),
    .ras_push    (ras_push),
    .ras_pop     (ras_pop),
    .pc          (pc),
    .npc         (npc),
    .redirect    (redirect),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fl, input logic br, input logic st, input logic pu,
                              input logic po, input logic [31:0] fpc, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [31:0] epc,
                              input logic eempty, input logic efull);
    vec_t v;
    v.fl = fl; v.br = br; v.st = st; v.pu = pu; v.po = po;
    v.fpc = fpc; v.op1 = op1; v.op2 = op2;
    v.epc = epc; v.eempty = eempty; v.efull = efull;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush_valid = 1'b0; br_taken = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
    flush_pc = '0; npc_op1 = '0; npc_op2 = '0;
  endtask

  // Drives one cycle of stimulus and records its expected outcome on the scoreboard.
  task automatic apply(input vec_t v);
    flush_valid = v.fl; br_taken = v.br; stall = v.st; ras_push = v.pu; ras_pop = v.po;
    flush_pc = v.fpc; npc_op1 = v.op1; npc_op2 = v.op2;
    sb.push_back(v);
  endtask

  task automatic test_reset();
    vec_t e;
    #2;
    checks++;
    if (pc !== 32'h0) begin
      failures++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
    end
    checks++;
    if ({ras_empty, ras_full} !== 2'b10) begin
      failures++; $display("FAIL reset_flags: got %b want %b", {ras_empty, ras_full}, 2'b10);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'(4 * i), 1, 0));
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.epc) begin
        failures++; $display("FAIL reset_seq[%0d]: got %h want %h", i, pc, e.epc);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(0, 1, 0, 0, 0, 0, 10, 14, 32'd24, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h10, 32'h5, 32'h14, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h18, 1, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      #1;
      checks++;
      if (npc !== v[i].epc) begin
        failures++; $display("FAIL branch_npc[%0d]: got %h want %h", i, npc, v[i].epc);
      end
      checks++;
      if (redirect !== v[i].br) begin
        failures++; $display("FAIL branch_redirect[%0d]: got %b want %b", i, redirect, v[i].br);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.epc) begin
        failures++; $display("FAIL branch_pc[%0d]: got %h want %h", i, pc, e.epc);
      end
    end
    flush_valid = 1'b1;
    #1;
    checks++;
    if (redirect !== 1'b1) begin
      failures++; $display("FAIL flush_redirect: got %b want 1", redirect);
    end
    flush_valid = 1'b0;
    #1;
  endtask

  task automatic test_priority();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h1C, 0, 0));
    v.push_back(mk(1, 1, 1, 1, 0, 32'h101, 32'h100, 32'h100, 32'h100, 1, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h100, 1, 0));
    v.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 32'h100, 1, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h100, 1, 0));
    v.push_back(mk(0, 1, 1, 0, 0, 0, 32'h300, 32'h0, 32'h300, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h304, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h308, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 32'h308, 0, 0));
    v.push_back(mk(0, 1, 0, 1, 0, 0, 32'h3F0, 32'h10, 32'h400, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h308, 1, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      #1;
      checks++;
      if (npc !== v[i].epc) begin
        failures++; $display("FAIL prio_npc[%0d]: got %h want %h", i, npc, v[i].epc);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.epc) begin
        failures++; $display("FAIL prio_pc[%0d]: got %h want %h", i, pc, e.epc);
      end
      checks++;
      if ({ras_empty, ras_full} !== {e.eempty, e.efull}) begin
        failures++;
        $display("FAIL prio_flags[%0d]: got %b want %b", i, {ras_empty, ras_full},
                 {e.eempty, e.efull});
      end
    end
  endtask

  task automatic test_ras();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(1, 0, 0, 0, 0, 32'h40, 0, 0, 32'h40, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h44, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h80, 32'h0, 32'h80, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h84, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h84, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h44, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h48, 1, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      #1;
      checks++;
      if (npc !== v[i].epc) begin
        failures++; $display("FAIL ras_npc[%0d]: got %h want %h", i, npc, v[i].epc);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.epc) begin
        failures++; $display("FAIL ras_pc[%0d]: got %h want %h", i, pc, e.epc);
      end
      checks++;
      if ({ras_empty, ras_full} !== {e.eempty, e.efull}) begin
        failures++;
        $display("FAIL ras_flags[%0d]: got %b want %b", i, {ras_empty, ras_full},
                 {e.eempty, e.efull});
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(1, 0, 0, 0, 0, 32'h1000, 0, 0, 32'h1000, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h1004, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h1008, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h100C, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h1010, 0, 1));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h1014, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h1014, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h1010, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h100C, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h1008, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h100C, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h1010, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 32'h1010, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h1014, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h100C, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 32'h1010, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h1010, 1, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      #1;
      checks++;
      if (npc !== v[i].epc) begin
        failures++; $display("FAIL ovf_npc[%0d]: got %h want %h", i, npc, v[i].epc);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.epc) begin
        failures++; $display("FAIL ovf_pc[%0d]: got %h want %h", i, pc, e.epc);
      end
      checks++;
      if ({ras_empty, ras_full} !== {e.eempty, e.efull}) begin
        failures++;
        $display("FAIL ovf_flags[%0d]: got %b want %b", i, {ras_empty, ras_full},
                 {e.eempty, e.efull});
      end
    end
  endtask

  task automatic test_wrap();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h20, 32'h10, 1, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 1, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.epc) begin
        failures++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, pc, e.epc);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_inputs();
    ras_push = 1'b1;
    tick();
    ras_push = 1'b0;
    checks++;
    if (ras_empty !== 1'b0) begin
      failures++; $display("FAIL midrst_setup: got %b want 0", ras_empty);
    end
    flush_valid = 1'b1; flush_pc = 32'h500; br_taken = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      failures++; $display("FAIL midrst_pc: got %h want %h", pc, 32'h0);
    end
    checks++;
    if ({ras_empty, ras_full} !== 2'b10) begin
      failures++; $display("FAIL midrst_flags: got %b want %b", {ras_empty, ras_full}, 2'b10);
    end
    tick();
    checks++;
    if (pc !== 32'h0) begin
      failures++; $display("FAIL midrst_hold: got %h want %h", pc, 32'h0);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h4) begin
      failures++; $display("FAIL midrst_release: got %h want %h", pc, 32'h4);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_ras();
    test_overflow();
    test_wrap();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
